// File: rtl/ddr2_cmd_timing_gate.sv
// DDR2 per-bank command timing gate: holds scheduler commands until tRCD/tRAS/tRP/tRFC
// are met, drops bank-state-illegal commands with an error pulse, and registers the DDR2 pins.
module ddr2_cmd_timing_gate #(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 14,
    parameter int T_RCD      = 4,
    parameter int T_RAS      = 12,
    parameter int T_RP       = 4,
    parameter int T_RFC      = 43,
    parameter int TW         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [BANK_WIDTH-1:0]         cmd_ba,
    input  logic [ROW_WIDTH-1:0]          cmd_addr,
    output logic                          ddr_cs_n,
    output logic                          ddr_ras_n,
    output logic                          ddr_cas_n,
    output logic                          ddr_we_n,
    output logic [BANK_WIDTH-1:0]         ddr_ba,
    output logic [ROW_WIDTH-1:0]          ddr_a,
    output logic [(2**BANK_WIDTH)-1:0]    bank_open,
    output logic                          err_illegal
);

    localparam int NUM_BANKS = 2**BANK_WIDTH;

    localparam logic [2:0] OP_ACT = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_WR  = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4;
    localparam logic [2:0] OP_REF = 3'd5;
    localparam logic [2:0] OP_MRS = 3'd6;

    localparam logic [TW-1:0] RCD_LOAD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RAS_LOAD = TW'(T_RAS - 1);
    localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
    localparam logic [TW-1:0] ONE      = TW'(1);

    // {cs_n, ras_n, cas_n, we_n} for each opcode; unknown ops map to deselect
    function automatic logic [3:0] encode_cmd(input logic [2:0] op);
        logic [3:0] enc;
        case (op)
            OP_ACT:  enc = 4'b0011;
            OP_RD:   enc = 4'b0101;
            OP_WR:   enc = 4'b0100;
            OP_PRE:  enc = 4'b0010;
            OP_REF:  enc = 4'b0001;
            OP_MRS:  enc = 4'b0000;
            default: enc = 4'b1111;
        endcase
        return enc;
    endfunction

    logic [NUM_BANKS-1:0] open_r;
    logic [TW-1:0]        rcd_t_r [NUM_BANKS];
    logic [TW-1:0]        ras_t_r [NUM_BANKS];
    logic [TW-1:0]        rp_t_r  [NUM_BANKS];
    logic [TW-1:0]        rfc_t_r;

    logic                 legal_s;
    logic                 timing_ok_s;
    logic                 issue_s;
    logic                 all_closed_s;
    logic                 ras_open_ok_s;
    logic                 rp_all_zero_s;
    logic                 pre_all_s;
    logic [NUM_BANKS-1:0] act_load_s;
    logic [NUM_BANKS-1:0] close_s;

    // Aggregate bank conditions, legality, timing gate and per-bank load strobes
    always_comb begin
        all_closed_s  = 1'b1;
        ras_open_ok_s = 1'b1;
        rp_all_zero_s = 1'b1;
        legal_s       = 1'b0;
        timing_ok_s   = 1'b0;
        act_load_s    = '0;
        close_s       = '0;
        pre_all_s     = cmd_addr[10];
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (open_r[b]) begin
                all_closed_s = 1'b0;
                if (ras_t_r[b] != '0) begin
                    ras_open_ok_s = 1'b0;
                end else begin
                    ras_open_ok_s = ras_open_ok_s;
                end
            end else begin
                all_closed_s = all_closed_s;
            end
            if (rp_t_r[b] != '0) begin
                rp_all_zero_s = 1'b0;
            end else begin
                rp_all_zero_s = rp_all_zero_s;
            end
        end
        case (cmd_op)
            OP_ACT: begin
                legal_s     = !open_r[cmd_ba];
                timing_ok_s = (rp_t_r[cmd_ba] == '0) && (rfc_t_r == '0);
            end
            OP_RD, OP_WR: begin
                legal_s     = open_r[cmd_ba];
                timing_ok_s = (rcd_t_r[cmd_ba] == '0);
            end
            OP_PRE: begin
                legal_s = 1'b1;
                if (pre_all_s) begin
                    timing_ok_s = ras_open_ok_s;
                end else begin
                    timing_ok_s = !open_r[cmd_ba] || (ras_t_r[cmd_ba] == '0);
                end
            end
            OP_REF, OP_MRS: begin
                legal_s     = all_closed_s;
                timing_ok_s = rp_all_zero_s && (rfc_t_r == '0);
            end
            default: begin
                legal_s     = 1'b0;
                timing_ok_s = 1'b0;
            end
        endcase
        issue_s   = cmd_valid && legal_s && timing_ok_s;
        cmd_ready = cmd_valid && (!legal_s || timing_ok_s);
        if (issue_s && (cmd_op == OP_ACT)) begin
            act_load_s[cmd_ba] = 1'b1;
        end else begin
            act_load_s = act_load_s;
        end
        if (issue_s && (cmd_op == OP_PRE)) begin
            if (pre_all_s) begin
                close_s = open_r;
            end else begin
                close_s[cmd_ba] = open_r[cmd_ba];
            end
        end else begin
            close_s = close_s;
        end
    end

    // Per-bank open flags and down-counters; a load beats the decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_r <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_t_r[b] <= '0;
                ras_t_r[b] <= '0;
                rp_t_r[b]  <= '0;
            end
        end else begin
            open_r <= (open_r | act_load_s) & ~close_s;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (act_load_s[b]) begin
                    rcd_t_r[b] <= RCD_LOAD;
                    ras_t_r[b] <= RAS_LOAD;
                end else begin
                    rcd_t_r[b] <= (rcd_t_r[b] != '0) ? rcd_t_r[b] - ONE : rcd_t_r[b];
                    ras_t_r[b] <= (ras_t_r[b] != '0) ? ras_t_r[b] - ONE : ras_t_r[b];
                end
                if (close_s[b]) begin
                    rp_t_r[b] <= RP_LOAD;
                end else begin
                    rp_t_r[b] <= (rp_t_r[b] != '0) ? rp_t_r[b] - ONE : rp_t_r[b];
                end
            end
        end
    end

    // Refresh recovery counter shared by all banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfc_t_r <= '0;
        end else if (issue_s && (cmd_op == OP_REF)) begin
            rfc_t_r <= RFC_LOAD;
        end else if (rfc_t_r != '0) begin
            rfc_t_r <= rfc_t_r - ONE;
        end else begin
            rfc_t_r <= rfc_t_r;
        end
    end

    // Registered DDR2 command pins; address/bank hold their value while deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} <= 4'b1111;
            ddr_ba      <= '0;
            ddr_a       <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= cmd_valid && !legal_s;
            if (issue_s) begin
                {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} <= encode_cmd(cmd_op);
                ddr_ba <= cmd_ba;
                ddr_a  <= cmd_addr;
            end else begin
                {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} <= 4'b1111;
                ddr_ba <= ddr_ba;
                ddr_a  <= ddr_a;
            end
        end
    end

    assign bank_open = open_r;

endmodule
